// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcode width, hard-wired zero register,
// the EX-stage control bundle and its bubble value, and the destination mux.
package pipe_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control and register-field portion of the ID/EX register.
    typedef struct packed {
        logic       valid;
        logic       reg_wre;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wd;
    } ex_ctrl_t;

    // A bubble carries no valid bit, no side effects and zeroed fields.
    localparam ex_ctrl_t CTRL_BUBBLE = '{
        valid:      1'b0,
        reg_wre:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        rs:         5'd0,
        rt:         5'd0,
        wd:         5'd0
    };

    localparam logic [ALUOP_W-1:0] ALUOP_BUBBLE = {ALUOP_W{1'b0}};

    // R-type writes rd, I-type writes rt.
    function automatic logic [4:0] dest_reg(input logic reg_dst,
                                            input logic [4:0] rd,
                                            input logic [4:0] rt);
        logic [4:0] wd_s;
        if (reg_dst) begin
            wd_s = rd;
        end else begin
            wd_s = rt;
        end
        return wd_s;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load sitting in EX and the
// instruction currently being decoded. Purely combinational.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_wd,
    input  logic       id_valid,
    input  logic       id_uses_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    logic rs_hit_s;
    logic rt_hit_s;
    logic ex_load_s;

    // A load targeting register zero never produces data anyone waits for.
    assign ex_load_s = ex_valid & ex_mem_read & (ex_wd != REG_ZERO);
    assign rs_hit_s  = (ex_wd == id_rs);
    assign rt_hit_s  = id_uses_rt & (ex_wd == id_rt);
    assign load_use  = ex_load_s & id_valid & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush handling
// (including a flush that arrives while the stage is held) and a
// saturating stall counter.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4:0]         IF_ID_Reg_RS,
    input  logic [4:0]         IF_ID_Reg_RT,
    input  logic [4:0]         IF_ID_Reg_RD,
    input  logic               ID_Valid,
    input  logic               ID_UsesRT,
    input  logic               ID_RegWre,
    input  logic               ID_RegDst,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic               Flush,
    input  logic               Hold,
    output logic [4:0]         ID_EX_Reg_RS,
    output logic [4:0]         ID_EX_Reg_RT,
    output logic [4:0]         ID_EX_Reg_WD,
    output logic               ID_EX_Valid,
    output logic               ID_EX_RegWre,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemToReg,
    output logic               ID_EX_ALUSrc,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
    output logic               Stall,
    output logic [CNT_W-1:0]   StallCount
);

    pipe_pkg::ex_ctrl_t  ctrl_r,  ctrl_d_s,  ctrl_cap_s;
    logic [ALUOP_W-1:0]  aluop_r, aluop_d_s;
    logic [DATA_W-1:0]   rd1_r,   rd1_d_s;
    logic [DATA_W-1:0]   rd2_r,   rd2_d_s;
    logic [DATA_W-1:0]   imm_r,   imm_d_s;
    logic                flush_pend_r, flush_pend_d_s;
    logic [CNT_W-1:0]    stall_cnt_r,  stall_cnt_d_s;
    logic                load_use_s;

    load_use_detect u_load_use_detect (
        .ex_valid    (ctrl_r.valid),
        .ex_mem_read (ctrl_r.mem_read),
        .ex_wd       (ctrl_r.wd),
        .id_valid    (ID_Valid),
        .id_uses_rt  (ID_UsesRT),
        .id_rs       (IF_ID_Reg_RS),
        .id_rt       (IF_ID_Reg_RT),
        .load_use    (load_use_s)
    );

    // A pending or current redirect, or a held stage, must not also freeze fetch.
    assign Stall = load_use_s & ~Flush & ~flush_pend_r & ~Hold;

    // Control bundle as it would be captured from decode this cycle.
    always_comb begin
        ctrl_cap_s            = pipe_pkg::CTRL_BUBBLE;
        ctrl_cap_s.valid      = 1'b1;
        ctrl_cap_s.reg_wre    = ID_RegWre;
        ctrl_cap_s.mem_read   = ID_MemRead;
        ctrl_cap_s.mem_write  = ID_MemWrite;
        ctrl_cap_s.mem_to_reg = ID_MemToReg;
        ctrl_cap_s.alu_src    = ID_ALUSrc;
        ctrl_cap_s.rs         = IF_ID_Reg_RS;
        ctrl_cap_s.rt         = IF_ID_Reg_RT;
        ctrl_cap_s.wd         = pipe_pkg::dest_reg(ID_RegDst, IF_ID_Reg_RD, IF_ID_Reg_RT);
    end

    // Next-state selection: hold, then flush, then load-use bubble, then capture.
    always_comb begin
        ctrl_d_s       = ctrl_r;
        aluop_d_s      = aluop_r;
        rd1_d_s        = rd1_r;
        rd2_d_s        = rd2_r;
        imm_d_s        = imm_r;
        flush_pend_d_s = flush_pend_r;
        stall_cnt_d_s  = stall_cnt_r;
        if (Hold) begin
            flush_pend_d_s = flush_pend_r | Flush;
        end else if (Flush | flush_pend_r) begin
            ctrl_d_s       = pipe_pkg::CTRL_BUBBLE;
            aluop_d_s      = {ALUOP_W{1'b0}};
            rd1_d_s        = {DATA_W{1'b0}};
            rd2_d_s        = {DATA_W{1'b0}};
            imm_d_s        = {DATA_W{1'b0}};
            flush_pend_d_s = 1'b0;
        end else if (load_use_s) begin
            ctrl_d_s  = pipe_pkg::CTRL_BUBBLE;
            aluop_d_s = {ALUOP_W{1'b0}};
            rd1_d_s   = {DATA_W{1'b0}};
            rd2_d_s   = {DATA_W{1'b0}};
            imm_d_s   = {DATA_W{1'b0}};
            if (&stall_cnt_r) begin
                stall_cnt_d_s = stall_cnt_r;
            end else begin
                stall_cnt_d_s = stall_cnt_r + CNT_W'(1);
            end
        end else if (ID_Valid) begin
            ctrl_d_s  = ctrl_cap_s;
            aluop_d_s = ID_ALUOp;
            rd1_d_s   = ID_ReadData1;
            rd2_d_s   = ID_ReadData2;
            imm_d_s   = ID_Imm;
        end else begin
            ctrl_d_s  = pipe_pkg::CTRL_BUBBLE;
            aluop_d_s = {ALUOP_W{1'b0}};
            rd1_d_s   = {DATA_W{1'b0}};
            rd2_d_s   = {DATA_W{1'b0}};
            imm_d_s   = {DATA_W{1'b0}};
        end
    end

    // Pipeline register, flush-pending flag and stall counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl_r       <= pipe_pkg::CTRL_BUBBLE;
            aluop_r      <= {ALUOP_W{1'b0}};
            rd1_r        <= {DATA_W{1'b0}};
            rd2_r        <= {DATA_W{1'b0}};
            imm_r        <= {DATA_W{1'b0}};
            flush_pend_r <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            ctrl_r       <= ctrl_d_s;
            aluop_r      <= aluop_d_s;
            rd1_r        <= rd1_d_s;
            rd2_r        <= rd2_d_s;
            imm_r        <= imm_d_s;
            flush_pend_r <= flush_pend_d_s;
            stall_cnt_r  <= stall_cnt_d_s;
        end
    end

    assign ID_EX_Valid     = ctrl_r.valid;
    assign ID_EX_RegWre    = ctrl_r.reg_wre;
    assign ID_EX_MemRead   = ctrl_r.mem_read;
    assign ID_EX_MemWrite  = ctrl_r.mem_write;
    assign ID_EX_MemToReg  = ctrl_r.mem_to_reg;
    assign ID_EX_ALUSrc    = ctrl_r.alu_src;
    assign ID_EX_Reg_RS    = ctrl_r.rs;
    assign ID_EX_Reg_RT    = ctrl_r.rt;
    assign ID_EX_Reg_WD    = ctrl_r.wd;
    assign ID_EX_ALUOp     = aluop_r;
    assign ID_EX_ReadData1 = rd1_r;
    assign ID_EX_ReadData2 = rd2_r;
    assign ID_EX_Imm       = imm_r;
    assign StallCount      = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts Stall and
// the next ID/EX contents per cycle; monitors pop and compare independently.
module tb_id_ex_stage;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic [4:0]         IF_ID_Reg_RS, IF_ID_Reg_RT, IF_ID_Reg_RD;
    logic               ID_Valid, ID_UsesRT, ID_RegWre, ID_RegDst;
    logic               ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc;
    logic [ALUOP_W-1:0] ID_ALUOp;
    logic [DATA_W-1:0]  ID_ReadData1, ID_ReadData2, ID_Imm;
    logic               Flush, Hold;
    logic [4:0]         ID_EX_Reg_RS, ID_EX_Reg_RT, ID_EX_Reg_WD;
    logic               ID_EX_Valid, ID_EX_RegWre, ID_EX_MemRead;
    logic               ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc;
    logic [ALUOP_W-1:0] ID_EX_ALUOp;
    logic [DATA_W-1:0]  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
    logic               Stall;
    logic [CNT_W-1:0]   StallCount;

    id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .IF_ID_Reg_RS(IF_ID_Reg_RS), .IF_ID_Reg_RT(IF_ID_Reg_RT), .IF_ID_Reg_RD(IF_ID_Reg_RD),
        .ID_Valid(ID_Valid), .ID_UsesRT(ID_UsesRT), .ID_RegWre(ID_RegWre), .ID_RegDst(ID_RegDst),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg),
        .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .Flush(Flush), .Hold(Hold),
        .ID_EX_Reg_RS(ID_EX_Reg_RS), .ID_EX_Reg_RT(ID_EX_Reg_RT), .ID_EX_Reg_WD(ID_EX_Reg_WD),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegWre(ID_EX_RegWre), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_Imm(ID_EX_Imm), .Stall(Stall), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic valid, uses_rt, regwre, regdst, memread, memwrite, memtoreg, alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0] d1, d2, imm;
        logic flush, hold;
    } stim_t;

    typedef struct packed {
        logic valid, regwre, memread, memwrite, memtoreg, alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [4:0] rs, rt, wd;
        logic [DATA_W-1:0] d1, d2, imm;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t  m;
    logic  m_fp;
    logic  stall_q[$];
    obs_t  state_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.valid = ID_EX_Valid;     o.regwre = ID_EX_RegWre;     o.memread = ID_EX_MemRead;
        o.memwrite = ID_EX_MemWrite; o.memtoreg = ID_EX_MemToReg; o.alusrc = ID_EX_ALUSrc;
        o.aluop = ID_EX_ALUOp;     o.rs = ID_EX_Reg_RS;          o.rt = ID_EX_Reg_RT;
        o.wd = ID_EX_Reg_WD;       o.d1 = ID_EX_ReadData1;       o.d2 = ID_EX_ReadData2;
        o.imm = ID_EX_Imm;         o.cnt = StallCount;
        return o;
    endfunction

    // Reference model: the instruction in EX is a load writing a nonzero
    // register that the decoding instruction reads.
    function automatic logic hazard(input obs_t ex, input stim_t s);
        logic reads;
        reads = (ex.wd == s.rs) || (s.uses_rt && ex.wd == s.rt);
        return ex.valid && ex.memread && (ex.wd != 5'd0) && s.valid && reads;
    endfunction

    function automatic obs_t empty_slot(input obs_t cur);
        obs_t b;
        b = '0;
        b.cnt = cur.cnt;
        return b;
    endfunction

    task automatic model_step(input stim_t s);
        logic h;
        int   c;
        h = hazard(m, s);
        stall_q.push_back(h && !s.flush && !m_fp && !s.hold);
        if (s.hold) begin
            m_fp = m_fp || s.flush;
        end else if (s.flush || m_fp) begin
            m    = empty_slot(m);
            m_fp = 1'b0;
        end else if (h) begin
            c = int'(m.cnt);
            if (c < (1 << CNT_W) - 1) c = c + 1;
            m     = empty_slot(m);
            m.cnt = CNT_W'(c);
        end else if (s.valid) begin
            m.valid = 1'b1; m.regwre = s.regwre; m.memread = s.memread;
            m.memwrite = s.memwrite; m.memtoreg = s.memtoreg; m.alusrc = s.alusrc;
            m.aluop = s.aluop; m.rs = s.rs; m.rt = s.rt;
            m.wd = s.regdst ? s.rd : s.rt;
            m.d1 = s.d1; m.d2 = s.d2; m.imm = s.imm;
        end else begin
            m = empty_slot(m);
        end
        state_q.push_back(m);
    endtask

    task automatic sync();
        @(negedge CLK);
    endtask

    task automatic apply(input stim_t s);
        RST = 1'b1;
        IF_ID_Reg_RS = s.rs; IF_ID_Reg_RT = s.rt; IF_ID_Reg_RD = s.rd;
        ID_Valid = s.valid; ID_UsesRT = s.uses_rt; ID_RegWre = s.regwre; ID_RegDst = s.regdst;
        ID_MemRead = s.memread; ID_MemWrite = s.memwrite; ID_MemToReg = s.memtoreg;
        ID_ALUSrc = s.alusrc; ID_ALUOp = s.aluop;
        ID_ReadData1 = s.d1; ID_ReadData2 = s.d2; ID_Imm = s.imm;
        Flush = s.flush; Hold = s.hold;
        model_step(s);
    endtask

    task automatic issue(input stim_t s);
        sync();
        apply(s);
    endtask

    task automatic do_reset();
        sync();
        RST  = 1'b0;
        m    = '0;
        m_fp = 1'b0;
        #1;
        check("async_reset_regs", observe(), '0);
        check("async_reset_stall", Stall, 1'b0);
        stall_q.push_back(1'b0);
        state_q.push_back(m);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.valid = ($urandom_range(0, 9) < 8); s.uses_rt = 1'($urandom);
        s.regwre = 1'($urandom); s.regdst = 1'($urandom); s.memread = 1'($urandom);
        s.memwrite = 1'($urandom); s.memtoreg = 1'($urandom); s.alusrc = 1'($urandom);
        s.aluop = ALUOP_W'($urandom); s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
        s.flush = ($urandom_range(0, 99) < 10); s.hold = ($urandom_range(0, 99) < 15);
        return s;
    endfunction

    // Monitor: combinational stall, sampled just before the active edge.
    initial begin
        logic e;
        forever begin
            @(negedge CLK);
            #4;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                check("stall", Stall, e);
            end
        end
    end

    // Monitor: registered stage contents, sampled just after the active edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                check("ex_regs", observe(), e);
            end
        end
    end

    initial begin
        stim_t nop, lw, use_i, x, y, h;
        RST = 1'b0; Flush = 1'b0; Hold = 1'b0;
        IF_ID_Reg_RS = 5'd0; IF_ID_Reg_RT = 5'd0; IF_ID_Reg_RD = 5'd0;
        ID_Valid = 1'b0; ID_UsesRT = 1'b0; ID_RegWre = 1'b0; ID_RegDst = 1'b0;
        ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemToReg = 1'b0; ID_ALUSrc = 1'b0;
        ID_ALUOp = '0; ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0;
        m = '0; m_fp = 1'b0;
        #2;
        check("reset_regs", observe(), '0);
        check("reset_stall", Stall, 1'b0);

        nop = '0;

        // Capture of an R-type instruction.
        x = nop; x.valid = 1'b1; x.rs = 5'd3; x.rt = 5'd4; x.rd = 5'd5; x.regdst = 1'b1;
        x.d1 = 32'h0000_1234; x.regwre = 1'b1; x.aluop = 3'd2;
        issue(x);
        sync();
        check("cap_wd", ID_EX_Reg_WD, 5'd5);
        check("cap_rd1", ID_EX_ReadData1, 32'h0000_1234);
        check("cap_valid", ID_EX_Valid, 1'b1);
        apply(nop);

        // Load-use pair: one stall cycle, one bubble, then capture.
        lw = nop; lw.valid = 1'b1; lw.memread = 1'b1; lw.memtoreg = 1'b1; lw.regwre = 1'b1;
        lw.alusrc = 1'b1; lw.rs = 5'd2; lw.rt = 5'd8; lw.imm = 32'h0000_0010;
        use_i = nop; use_i.valid = 1'b1; use_i.rs = 5'd8; use_i.rt = 5'd9; use_i.uses_rt = 1'b1;
        use_i.regwre = 1'b1; use_i.regdst = 1'b1; use_i.rd = 5'd10;
        issue(lw);
        sync();
        apply(use_i);
        #1 check("lu_stall", Stall, 1'b1);
        sync();
        check("lu_bubble", ID_EX_Valid, 1'b0);
        check("lu_cnt", StallCount, 4'd1);
        apply(use_i);
        #1 check("lu_no_restall", Stall, 1'b0);
        sync();
        check("lu_capture_rs", ID_EX_Reg_RS, 5'd8);
        check("lu_capture_wd", ID_EX_Reg_WD, 5'd10);
        apply(nop);

        // RT match without RT use, and load into register zero.
        issue(lw);
        y = nop; y.valid = 1'b1; y.rs = 5'd1; y.rt = 5'd8; y.uses_rt = 1'b0;
        sync(); apply(y);
        #1 check("rt_unused_stall", Stall, 1'b0);
        x = lw; x.rt = 5'd0;
        issue(x);
        y = nop; y.valid = 1'b1; y.rs = 5'd0; y.uses_rt = 1'b1;
        sync(); apply(y);
        #1 check("wd_zero_stall", Stall, 1'b0);
        sync();
        check("wd_zero_no_bubble", ID_EX_Valid, 1'b1);
        apply(nop);

        // Hold for three cycles with a flush in the middle one.
        x = nop; x.valid = 1'b1; x.rd = 5'd7; x.regdst = 1'b1; x.d1 = 32'h0000_AAAA;
        issue(x);
        h = x; h.d1 = 32'h5555_0000; h.hold = 1'b1;
        issue(h);
        h.flush = 1'b1; issue(h);
        h.flush = 1'b0; issue(h);
        sync();
        check("hold_frozen_d1", ID_EX_ReadData1, 32'h0000_AAAA);
        check("hold_frozen_valid", ID_EX_Valid, 1'b1);
        y = nop; y.valid = 1'b1; y.rs = 5'd6;
        apply(y);
        sync();
        check("hold_flush_bubble", ID_EX_Valid, 1'b0);
        apply(y);
        sync();
        check("flushpend_cleared", ID_EX_Valid, 1'b1);
        apply(nop);

        // Flush coinciding with load-use.
        issue(lw);
        y = use_i; y.flush = 1'b1;
        sync(); apply(y);
        #1 check("flush_lu_stall", Stall, 1'b0);
        sync();
        check("flush_lu_bubble", ID_EX_Valid, 1'b0);
        check("flush_lu_cnt", StallCount, 4'd1);
        apply(nop);

        // Drive the counter into saturation.
        for (int i = 0; i < 20; i++) begin
            issue(lw);
            issue(use_i);
            issue(use_i);
        end
        sync();
        check("cnt_saturated", StallCount, 4'hF);
        apply(nop);

        // Reset while a flush is pending under hold.
        issue(x);
        h = x; h.hold = 1'b1; h.flush = 1'b1;
        issue(h);
        do_reset();
        y = nop; y.valid = 1'b1; y.rs = 5'd4; y.d2 = 32'hCAFE_0001;
        issue(y);
        sync();
        check("post_reset_capture", ID_EX_Valid, 1'b1);
        check("post_reset_cnt", StallCount, 4'd0);
        apply(nop);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                issue(rand_stim());
            end
        end
        issue(nop);
        sync();
        sync();
        check("scoreboard_drained", 32'(stall_q.size() + state_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: DATA_W, 32, operand/immediate width; ALUOP_W, 3, ALU opcode width; CNT_W, 16, stall-counter width.
REQ-002 SHALL have ports CLK in 1 clock; RST in 1 reset (one clock; reset is asynchronous and active-low).
REQ-003 SHALL have inputs IF_ID_Reg_RS, IF_ID_Reg_RT, IF_ID_Reg_RD in 5 each: decoded register fields.
REQ-004 SHALL have inputs ID_Valid, ID_UsesRT, ID_RegWre, ID_RegDst, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc in 1 each: decode valid and control.
REQ-005 SHALL have inputs ID_ALUOp in ALUOP_W; ID_ReadData1, ID_ReadData2, ID_Imm in DATA_W each.
REQ-006 SHALL have inputs Flush in 1 (EX branch/jump redirect) and Hold in 1 (downstream memory wait, freezes stage).
REQ-007 SHALL have outputs ID_EX_Reg_RS, ID_EX_Reg_RT, ID_EX_Reg_WD out 5 each: source fields for the forwarding unit, destination register.
REQ-008 SHALL have outputs ID_EX_Valid, ID_EX_RegWre, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc out 1; ID_EX_ALUOp out ALUOP_W; ID_EX_ReadData1/2, ID_EX_Imm out DATA_W.
REQ-009 SHALL have outputs Stall out 1 (freeze PC and IF/ID) and StallCount out CNT_W.

Function
REQ-010 SHALL compute LoadUse combinationally = ID_EX_Valid & ID_EX_MemRead & (ID_EX_Reg_WD != 0) & ID_Valid & ((ID_EX_Reg_WD == IF_ID_Reg_RS) | (ID_UsesRT & ID_EX_Reg_WD == IF_ID_Reg_RT)).
REQ-011 SHALL drive Stall = LoadUse & ~Flush & ~FlushPend & ~Hold, combinationally, same cycle.
REQ-012 SHALL hold internal flag FlushPend (1 bit) recording a Flush seen while Hold=1.
REQ-013 SHALL evaluate per rising CLK, first match wins: Hold, Flush|FlushPend, LoadUse, ID_Valid, else.
REQ-014 Hold=1: all output registers and StallCount keep value; FlushPend <= FlushPend | Flush.
REQ-015 Flush|FlushPend (Hold=0): load bubble; FlushPend <= 0; StallCount unchanged.
REQ-016 LoadUse (no Hold/flush): load bubble; StallCount += 1, saturating at all-ones.
REQ-017 ID_Valid=1 otherwise: capture all ID_* into ID_EX_*; ID_EX_Valid <= 1; ID_EX_Reg_WD <= ID_RegDst ? IF_ID_Reg_RD : IF_ID_Reg_RT; ID_EX_Reg_RS/RT <= IF_ID fields.
REQ-018 ID_Valid=0 otherwise: load bubble.
REQ-019 Bubble = ID_EX_Valid, RegWre, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp, Reg_RS/RT/WD, ReadData1/2, Imm all zero.
REQ-020 Latency: one cycle ID to EX; a load-use pair costs exactly one bubble; Stall never asserts two consecutive cycles for the same pair.
REQ-021 WD=0 destinations SHALL never cause LoadUse (register zero hard-wired).

Reset
REQ-022 RST=0 SHALL asynchronously force all output registers to bubble, FlushPend=0, StallCount=0.
REQ-023 Reset mid-Hold or with FlushPend=1 SHALL discard pending state; first post-reset edge follows REQ-013 normally.

Structure
REQ-024 Bubble constant, ALUOP_W, register-zero constant SHALL live in shared package pipe_pkg.
REQ-025 Hazard compare (REQ-010) SHALL be a sub-module load_use_detect; registers stay in id_ex_stage.

Verification
REQ-026 Capture: ID_Valid=1, RS=3, RT=4, RD=5, RegDst=1, ReadData1=0x1234 -> next cycle ID_EX_Reg_WD=5, ID_EX_ReadData1=0x1234, Valid=1.
REQ-027 Load-use: EX holds lw WD=8; ID RS=8 -> Stall=1 that cycle, next cycle bubble, StallCount=1, following cycle instruction captured, Stall=0.
REQ-028 RT-only match with ID_UsesRT=0, and WD=0 with RS=0 -> Stall=0, no bubble.
REQ-029 Hold=1 for 3 cycles with Flush pulsed in cycle 2 -> outputs frozen; first edge after Hold drops loads bubble, FlushPend cleared.
REQ-030 Flush and LoadUse same cycle -> Stall=0, bubble, StallCount unchanged; StallCount at 0xFFFF plus LoadUse stays 0xFFFF.
REQ-031 RST low mid-stream with FlushPend=1 -> immediate bubble outputs, StallCount=0, FlushPend=0.
